// File: rtl/main_controller_multicycle_if.sv
// Control bus between the multicycle RV32I controller and its datapath/memory port.
// The controller uses the master modport; the datapath side uses slave.
interface main_controller_multicycle_if #(
   parameter int unsigned ALUOP_W = 4
);
   logic [6:0]         Opcode;
   logic [2:0]         Funct3;
   logic [6:0]         Funct7;
   logic [1:0]         Comp;
   logic               MemReady;
   logic               PCWrite;
   logic               IRWrite;
   logic               RegWrite;
   logic               MemRead;
   logic               MemWrite;
   logic               AdrSrc;
   logic [1:0]         ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [ALUOP_W-1:0] ALUOp;
   logic [1:0]         ResultSrc;
   logic               Illegal;
   logic [4:0]         State;

   modport master (
      input  Opcode, Funct3, Funct7, Comp, MemReady,
      output PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Illegal, State
   );

   modport slave (
      output Opcode, Funct3, Funct7, Comp, MemReady,
      input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Illegal, State
   );
endinterface

// File: rtl/main_controller_multicycle.sv
// Multicycle RV32I Moore control FSM with memory-ready stalls and sticky illegal halt.
// Optional macro RV32M_EN enables mul/div/rem decode and the MDWAIT divide counter.
module main_controller_multicycle #(
   parameter int unsigned ALUOP_W    = 4,
   parameter int unsigned DIV_CYCLES = 32
) (
   input logic                          clk,
   input logic                          rst,
   main_controller_multicycle_if.master io_bus
);
   localparam logic [6:0] OP_LOAD = 7'h03, OP_IMM  = 7'h13, OP_AUIPC = 7'h17, OP_STORE = 7'h23,
                          OP_REG  = 7'h33, OP_LUI  = 7'h37, OP_BRANCH = 7'h63, OP_JALR = 7'h67,
                          OP_JAL  = 7'h6F;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR = 4'd3,
                          ALU_AND = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SLT = 4'd7,
                          ALU_MUL = 4'd8, ALU_DIV = 4'd9, ALU_SRA = 4'd10, ALU_SLTU = 4'd11,
                          ALU_REM = 4'd12, ALU_PASSB = 4'd13, ALU_NA = 4'd15;

   localparam logic [4:0] S_FETCH = 5'd0, S_DECODE = 5'd1, S_MEMADR = 5'd2, S_MEMRD = 5'd3,
                          S_MEMWB = 5'd4, S_MEMWR = 5'd5, S_EXEC_R = 5'd6, S_EXEC_I = 5'd7,
                          S_ALUWB = 5'd8, S_BRANCH = 5'd9, S_JAL = 5'd10, S_JALR = 5'd11,
                          S_LINK = 5'd12, S_LUI = 5'd13, S_AUIPC = 5'd14, S_MDWAIT = 5'd15,
                          S_HALT = 5'd16;

   localparam logic [1:0] SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2;
   localparam logic [1:0] SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2;
   localparam logic [1:0] RES_ALUOUT = 2'd0, RES_MDR = 2'd1, RES_ALURESULT = 2'd2;
   localparam logic [1:0] CMP_EQU = 2'd0, CMP_LST = 2'd1;

   if (ALUOP_W < 4) begin : g_chk_aluop_w
      $error("ALUOP_W must be at least 4");
   end
   if (DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_chk_div_cycles
      $error("DIV_CYCLES must be within 1..255");
   end

   logic [4:0] r_state, w_next_state;
   logic       r_illegal, w_set_illegal;
   logic [3:0] w_dec_op;
   logic       w_dec_ok;
   logic       w_taken;
   logic       w_pc_write, w_ir_write, w_reg_write, w_mem_read, w_mem_write, w_adr_src;
   logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src;
   logic [3:0] w_alu_op;
`ifdef RV32M_EN
   logic       w_dec_md;
   logic       w_md_done;
   logic [7:0] r_md_cnt;
`endif

   function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
      case (f3)
         3'd0:    return ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // Instruction legality and ALU operation, from the IR fields held since FETCH
   always_comb begin
      w_dec_op = ALU_NA;
      w_dec_ok = 1'b0;
`ifdef RV32M_EN
      w_dec_md = 1'b0;
`endif
      case (io_bus.Opcode)
         OP_REG: begin
            if (io_bus.Funct7 == 7'h00) begin
               w_dec_ok = 1'b1;
               w_dec_op = f3_to_alu(io_bus.Funct3);
            end else if (io_bus.Funct7 == 7'h20 &&
                         (io_bus.Funct3 == 3'd0 || io_bus.Funct3 == 3'd5)) begin
               w_dec_ok = 1'b1;
               w_dec_op = (io_bus.Funct3 == 3'd0) ? ALU_SUB : ALU_SRA;
            end
`ifdef RV32M_EN
            else if (io_bus.Funct7 == 7'h01) begin
               w_dec_ok = 1'b1;
               w_dec_md = io_bus.Funct3[2];
               w_dec_op = !io_bus.Funct3[2] ? ALU_MUL : (io_bus.Funct3[1] ? ALU_REM : ALU_DIV);
            end
`endif
         end
         OP_IMM: begin
            if (io_bus.Funct3 == 3'd1) begin
               w_dec_ok = (io_bus.Funct7 == 7'h00);
               w_dec_op = ALU_SLL;
            end else if (io_bus.Funct3 == 3'd5) begin
               w_dec_ok = (io_bus.Funct7 == 7'h00) || (io_bus.Funct7 == 7'h20);
               w_dec_op = io_bus.Funct7[5] ? ALU_SRA : ALU_SRL;
            end else begin
               w_dec_ok = 1'b1;
               w_dec_op = f3_to_alu(io_bus.Funct3);
            end
         end
         OP_LOAD, OP_STORE:        w_dec_ok = (io_bus.Funct3 == 3'd2);
         OP_BRANCH:                w_dec_ok = (io_bus.Funct3[2:1] != 2'b01);
         OP_JALR:                  w_dec_ok = (io_bus.Funct3 == 3'd0);
         OP_JAL, OP_LUI, OP_AUIPC: w_dec_ok = 1'b1;
         default:                  w_dec_ok = 1'b0;
      endcase
   end

   always_comb begin
      case (io_bus.Funct3)
         3'd0:       w_taken = (io_bus.Comp == CMP_EQU);
         3'd1:       w_taken = (io_bus.Comp != CMP_EQU);
         3'd4, 3'd6: w_taken = (io_bus.Comp == CMP_LST);
         3'd5, 3'd7: w_taken = (io_bus.Comp != CMP_LST);
         default:    w_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_set_illegal) r_illegal <= 1'b1;
      end
   end

`ifdef RV32M_EN
   // Held at zero outside MDWAIT, so every entry starts counting from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_md_cnt <= 8'd0;
      else if (r_state != S_MDWAIT) r_md_cnt <= 8'd0;
      else                          r_md_cnt <= r_md_cnt + 8'd1;
   end
   assign w_md_done = (r_md_cnt == 8'(DIV_CYCLES - 1));
`endif

   // Next state and Moore outputs
   always_comb begin
      w_next_state  = r_state;
      w_set_illegal = 1'b0;
      w_pc_write    = 1'b0;
      w_ir_write    = 1'b0;
      w_reg_write   = 1'b0;
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_adr_src     = 1'b0;
      w_alu_src_a   = SRCA_PC;
      w_alu_src_b   = SRCB_RS2;
      w_result_src  = RES_ALUOUT;
      w_alu_op      = ALU_NA;
      case (r_state)
         S_FETCH: begin
            w_mem_read   = 1'b1;
            w_alu_src_b  = SRCB_FOUR;
            w_alu_op     = ALU_ADD;
            w_result_src = RES_ALURESULT;
            if (io_bus.MemReady) begin
               w_ir_write   = 1'b1;
               w_pc_write   = 1'b1;
               w_next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            w_alu_src_a = SRCA_OLDPC;
            w_alu_src_b = SRCB_IMM;
            w_alu_op    = ALU_ADD;
            if (!w_dec_ok) begin
               w_set_illegal = 1'b1;
               w_next_state  = S_HALT;
            end else begin
               case (io_bus.Opcode)
                  OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                  OP_REG:            w_next_state = S_EXEC_R;
                  OP_IMM:            w_next_state = S_EXEC_I;
                  OP_BRANCH:         w_next_state = S_BRANCH;
                  OP_JAL:            w_next_state = S_JAL;
                  OP_JALR:           w_next_state = S_JALR;
                  OP_LUI:            w_next_state = S_LUI;
                  OP_AUIPC:          w_next_state = S_AUIPC;
                  default:           w_next_state = S_HALT;
               endcase
            end
         end
         S_MEMADR: begin
            w_alu_src_a  = SRCA_RS1;
            w_alu_src_b  = SRCB_IMM;
            w_alu_op     = ALU_ADD;
            w_next_state = (io_bus.Opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            w_adr_src  = 1'b1;
            if (io_bus.MemReady) w_next_state = S_MEMWB;
         end
         S_MEMWB: begin
            w_reg_write  = 1'b1;
            w_result_src = RES_MDR;
            w_next_state = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_write = 1'b1;
            w_adr_src   = 1'b1;
            if (io_bus.MemReady) w_next_state = S_FETCH;
         end
         S_EXEC_R: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_RS2;
            w_alu_op    = w_dec_op;
`ifdef RV32M_EN
            w_next_state = w_dec_md ? S_MDWAIT : S_ALUWB;
`else
            w_next_state = S_ALUWB;
`endif
         end
         S_EXEC_I: begin
            w_alu_src_a  = SRCA_RS1;
            w_alu_src_b  = SRCB_IMM;
            w_alu_op     = w_dec_op;
            w_next_state = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write  = 1'b1;
            w_next_state = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_a  = SRCA_RS1;
            w_alu_op     = ALU_SUB;
            w_pc_write   = w_taken;
            w_next_state = S_FETCH;
         end
         S_JAL: begin
            w_pc_write   = 1'b1;
            w_alu_src_a  = SRCA_OLDPC;
            w_alu_src_b  = SRCB_FOUR;
            w_alu_op     = ALU_ADD;
            w_next_state = S_ALUWB;
         end
         S_JALR: begin
            w_pc_write   = 1'b1;
            w_result_src = RES_ALURESULT;
            w_alu_src_a  = SRCA_RS1;
            w_alu_src_b  = SRCB_IMM;
            w_alu_op     = ALU_ADD;
            w_next_state = S_LINK;
         end
         S_LINK: begin
            w_alu_src_a  = SRCA_OLDPC;
            w_alu_src_b  = SRCB_FOUR;
            w_alu_op     = ALU_ADD;
            w_next_state = S_ALUWB;
         end
         S_LUI: begin
            w_alu_src_b  = SRCB_IMM;
            w_alu_op     = ALU_PASSB;
            w_next_state = S_ALUWB;
         end
         S_AUIPC: begin
            w_alu_src_a  = SRCA_OLDPC;
            w_alu_src_b  = SRCB_IMM;
            w_alu_op     = ALU_ADD;
            w_next_state = S_ALUWB;
         end
         S_MDWAIT: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_op    = w_dec_op;
`ifdef RV32M_EN
            w_next_state = w_md_done ? S_ALUWB : S_MDWAIT;
`else
            w_next_state = S_ALUWB;
`endif
         end
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_FETCH;
      endcase
   end

   // Enables and strobes drop immediately while reset is held
   assign io_bus.PCWrite   = w_pc_write  & ~rst;
   assign io_bus.IRWrite   = w_ir_write  & ~rst;
   assign io_bus.RegWrite  = w_reg_write & ~rst;
   assign io_bus.MemRead   = w_mem_read  & ~rst;
   assign io_bus.MemWrite  = w_mem_write & ~rst;
   assign io_bus.AdrSrc    = w_adr_src;
   assign io_bus.ALUSrcA   = w_alu_src_a;
   assign io_bus.ALUSrcB   = w_alu_src_b;
   assign io_bus.ResultSrc = w_result_src;
   assign io_bus.ALUOp     = ALUOP_W'(w_alu_op);
   assign io_bus.Illegal   = r_illegal;
   assign io_bus.State     = r_state;
endmodule

// File: doc/main_controller_multicycle.md
# main_controller_multicycle

Multicycle RV32I control unit replacing the single-cycle decoder. A Moore FSM sequences fetch, decode, execute, memory and writeback over several clocks and stalls on a memory ready handshake. ALU opcode width and divide latency are parameters; the ALU code set adds arithmetic and unsigned variants. It sits between the shared instruction/data memory port and the multicycle datapath (IR, OldPC, A/B, ALUOut, MDR registers).

## Interface
- ALUOP_W, 4: ALUOp width, minimum 4.
- DIV_CYCLES, 32: cycles spent in MDWAIT for div/rem, range 1..255.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Opcode  in  7  IR[6:0]; Funct3 in 3 IR[14:12]; Funct7 in 7 IR[31:25]. Held stable by IR after FETCH.
- Comp  in  2  datapath compare: 0 EQU, 1 LST, 2 GRT, 3 NA. Signedness follows Funct3[1].
- MemReady  in  1  memory has completed the current access.
- PCWrite, IRWrite, RegWrite, MemRead, MemWrite  out  1 each  enables and strobes.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- ALUSrcA  out  2  0 PC, 1 OldPC, 2 rs1.
- ALUSrcB  out  2  0 rs2, 1 Imm, 2 const 4.
- ALUOp  out  ALUOP_W  ADD0 SUB1 XOR2 OR3 AND4 SLL5 SRL6 SLT7 MUL8 DIV9 SRA10 SLTU11 REM12 PASSB13 NA15.
- ResultSrc  out  2  0 ALUOut, 1 MDR, 2 ALUResult.
- Illegal  out  1  sticky illegal-instruction flag.
- State  out  5  current state, for debug.

## Operation
- States:
  - FETCH0: MemRead, AdrSrc=0, PC+4 computed on the ALU. When MemReady, assert IRWrite and PCWrite (ResultSrc=2) and go to DECODE. Otherwise stay.
  - DECODE1: compute OldPC+Imm into ALUOut, then dispatch by opcode.
  - MEMADR2: rs1+Imm. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD3: MemRead, AdrSrc=1. Stays until MemReady, then MEMWB.
  - MEMWB4: RegWrite with ResultSrc=1.
  - MEMWR5: MemWrite, AdrSrc=1. Stays until MemReady, then FETCH.
  - EXEC_R6: ALUSrcA=2, ALUSrcB=0. Goes to ALUWB.
  - EXEC_I7: ALUSrcA=2, ALUSrcB=1. Goes to ALUWB.
  - ALUWB8: RegWrite with ResultSrc=0, then FETCH.
  - BRANCH9: PCWrite with ResultSrc=0 only if taken, then FETCH.
  - JAL10: PCWrite from ALUOut; OldPC+4 goes to ALUOut. Then ALUWB.
  - JALR11: rs1+Imm, PCWrite with ResultSrc=2, then LINK12.
  - LINK12: OldPC+4, then ALUWB.
  - LUI13: PASSB of Imm, then ALUWB.
  - AUIPC14: OldPC+Imm, then ALUWB.
  - MDWAIT15: counts DIV_CYCLES, then ALUWB.
  - HALT16: absorbing; all enables 0.
- Branch taken conditions:
  - beq: Comp==EQU. bne: Comp!=EQU.
  - blt/bltu: Comp==LST. bge/bgeu: Comp!=LST.
  - Funct3 2 or 3 is illegal.
- ALUOp decode:
  - R-type and I-type map to their own codes: sra/srai → SRA, sltu/sltiu → SLTU, sub → SUB.
  - slli/srli require Funct7=0x00; srai requires 0x20.
  - R-type with any other Funct7 is illegal, except as allowed under Configuration.
- Illegal handling: any unrecognised opcode or funct combination in DECODE sets Illegal and goes to HALT. Only rst leaves HALT.
- Outputs are decoded from State (Moore). Exceptions: FETCH IRWrite/PCWrite are gated by MemReady, and BRANCH PCWrite is gated by Comp.

## Timing
- Reset, while rst is high and immediately after: State=FETCH, Illegal=0, MDWAIT counter=0. All enables and strobes are forced to 0 while rst=1.
- Cycle counts with MemReady tied high:
  - R/I-ALU, lui, auipc, sw: 4.
  - lw: 5.
  - Branch: 3.
  - jal: 4.
  - jalr: 5.
  - div/rem: 4+DIV_CYCLES.
- Each cycle MemReady is low in FETCH, MEMRD or MEMWR adds one cycle. A strobe stays high for the whole wait.
- The MDWAIT counter loads at entry and exits when it reaches DIV_CYCLES-1. DIV_CYCLES=1 therefore gives one MDWAIT cycle.
- rst asserted mid-access: the FSM returns to FETCH asynchronously and any pending MemRead/MemWrite drops in the same cycle.
- A MemReady pulse in any state other than FETCH, MEMRD or MEMWR is ignored.

## Configuration
- RV32M_EN defined: R-type with Funct7=0x01 is legal.
  - Funct3 0..3 (mul family) → MUL, via EXEC_R.
  - Funct3 4..5 → DIV, via MDWAIT.
  - Funct3 6..7 → REM, via MDWAIT.
- RV32M_EN undefined: Funct7=0x01 is illegal (HALT). MDWAIT is never entered and its counter is not synthesised.

## Test plan
- add (Funct7 0x00, Funct3 0, Opcode 0x33), MemReady=1 → states 0,1,6,8,0; RegWrite high exactly in cycle 4; ALUOp=0.
- lw with MemReady low 3 cycles in MEMRD → MemRead held 4 cycles at AdrSrc=1; RegWrite with ResultSrc=1 one cycle after MemReady.
- beq with Comp=EQU, then Comp=GRT → PCWrite in BRANCH for the first and absent for the second; both return to FETCH after 3 cycles.
- srai (Funct7 0x20, Funct3 5, Opcode 0x13) → ALUOp=10; sltiu → ALUOp=11.
- Opcode 0x7F → Illegal=1 and State=16 after DECODE, held 10 cycles; rst pulse → State=0, Illegal=0.
- With RV32M_EN and DIV_CYCLES=3: div → exactly 3 MDWAIT cycles, ALUOp=9. Without the macro: same encoding → Illegal=1.
